vend_ctrl_multi: RTL and testbench

- Parametrised next-generation vending controller.
- Accepts nickel, dime and quarter pulses into a saturating credit register, and serves NUM_ITEMS product channels, each with its own stock counter.
- Vends on a one-hot selection, then returns change one nickel per cycle; also supports cancel/refund and restock.
- Sits between the coin-acceptor/button debouncers and the dispenser solenoid drivers on the board top level.

---
 rtl/vend_if.sv | 45 ++++
 rtl/vend_ctrl_multi.sv | 163 ++++++++++++++++
 tb/tb_vend_ctrl_multi.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_if.sv
// -----------------------------------------------------------------------------
// vend_if
// Bundles the vending controller's front-panel / dispenser signals.
//   master : board side (debouncers drive coins, selection, cancel, restock;
//            dispenser drivers consume give/change/reject/status)
//   slave  : vend_ctrl_multi side
// Signals:
//   N, D, Q        coin pulses (1, 2, 5 nickel units)
//   sel            one-hot product selection pulse
//   cancel         refund request pulse
//   restock        reload every stock counter
//   give           one-hot dispense pulse
//   change_nickel  eject one nickel this cycle
//   coin_reject    inserted coin returned
//   credit         current credit in nickels
//   sold_out       per-channel empty flags
//   busy           controller is vending or paying out change
// -----------------------------------------------------------------------------
interface vend_if #(
    parameter int NUM_ITEMS = 2,
    parameter int CREDIT_W  = 5
);
    logic                 N;
    logic                 D;
    logic                 Q;
    logic [NUM_ITEMS-1:0] sel;
    logic                 cancel;
    logic                 restock;
    logic [NUM_ITEMS-1:0] give;
    logic                 change_nickel;
    logic                 coin_reject;
    logic [CREDIT_W-1:0]  credit;
    logic [NUM_ITEMS-1:0] sold_out;
    logic                 busy;

    modport master (
        output N, D, Q, sel, cancel, restock,
        input  give, change_nickel, coin_reject, credit, sold_out, busy
    );

    modport slave (
        input  N, D, Q, sel, cancel, restock,
        output give, change_nickel, coin_reject, credit, sold_out, busy
    );
endinterface

// File: rtl/vend_ctrl_multi.sv
// -----------------------------------------------------------------------------
// vend_ctrl_multi
// Multi-channel vending controller. Coins accumulate into a saturating credit
// register (nickel units); a one-hot selection with enough credit and stock
// dispenses one item, after which the leftover credit is paid back one nickel
// per cycle. Cancel refunds the whole credit the same way. Restock reloads all
// per-channel stock counters.
// Ports:
//   CLK    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    vend_if.slave (coins/sel/cancel/restock in; give/change/reject/
//          credit/sold_out/busy out, all registered or register-decoded)
// -----------------------------------------------------------------------------
module vend_ctrl_multi #(
    parameter int NUM_ITEMS  = 2,
    parameter int CREDIT_W   = 5,
    parameter int MAX_CREDIT = 20,
    parameter int PRICE      = 9,
    parameter int STOCK_W    = 4,
    parameter int STOCK_MAX  = 10
) (
    input  logic   CLK,
    input  logic   reset,
    vend_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_C      = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [STOCK_W-1:0]  STOCK_FULL = STOCK_W'(STOCK_MAX);

    // Value of a single coin; only meaningful when exactly one pulse is high.
    function automatic logic [CREDIT_W:0] coin_value(input logic n, input logic d);
        if (n)      return (CREDIT_W+1)'(1);
        else if (d) return (CREDIT_W+1)'(2);
        else        return (CREDIT_W+1)'(5);
    endfunction

    state_t                              state_q,  state_d;
    logic [CREDIT_W-1:0]                 credit_q, credit_d;
    logic [NUM_ITEMS-1:0][STOCK_W-1:0]   stock_q,  stock_d;
    logic [NUM_ITEMS-1:0]                give_q,   give_d;
    logic                                change_q, change_d;
    logic                                reject_q, reject_d;

    logic [NUM_ITEMS-1:0] sold_out;
    logic                 coin_any;
    logic                 coin_multi;
    logic [CREDIT_W:0]    credit_sum;
    logic                 sel_ok;

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            sold_out[i] = (stock_q[i] == '0);
        end
    end

    assign coin_any   = bus.N | bus.D | bus.Q;
    assign coin_multi = (bus.N & bus.D) | (bus.N & bus.Q) | (bus.D & bus.Q);
    assign credit_sum = {1'b0, credit_q} + coin_value(bus.N, bus.D);

    // A selection of an empty channel, or any non one-hot pattern, is ignored.
    assign sel_ok = $onehot(bus.sel) && (credit_q >= PRICE_C) &&
                    ((bus.sel & ~sold_out) != '0);

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        stock_d  = stock_q;
        give_d   = '0;
        change_d = 1'b0;
        reject_d = 1'b0;

        unique case (state_q)
            IDLE, CREDIT: begin
                if (bus.cancel && (state_q == CREDIT)) begin
                    // Refund: the first nickel leaves on entry to CHANGE.
                    state_d  = CHANGE;
                    credit_d = credit_q - CREDIT_W'(1);
                    change_d = 1'b1;
                    reject_d = coin_any;
                end else if (sel_ok) begin
                    state_d  = VEND;
                    give_d   = bus.sel;
                    credit_d = credit_q - PRICE_C;
                    reject_d = coin_any;
                    for (int i = 0; i < NUM_ITEMS; i++) begin
                        if (bus.sel[i]) stock_d[i] = stock_q[i] - STOCK_W'(1);
                    end
                end else if (coin_any) begin
                    if (!coin_multi && (credit_sum <= MAX_C)) begin
                        credit_d = credit_sum[CREDIT_W-1:0];
                        state_d  = CREDIT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end

            VEND: begin
                reject_d = coin_any;
                if (credit_q != '0) begin
                    state_d  = CHANGE;
                    credit_d = credit_q - CREDIT_W'(1);
                    change_d = 1'b1;
                end else begin
                    state_d  = IDLE;
                end
            end

            CHANGE: begin
                // Each pulse is paired with its decrement, so the cycle that
                // sees credit == 0 has already paid the last nickel.
                reject_d = coin_any;
                if (credit_q != '0) begin
                    credit_d = credit_q - CREDIT_W'(1);
                    change_d = 1'b1;
                end else begin
                    state_d  = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // Restock overrides any same-cycle decrement.
        if (bus.restock) begin
            stock_d = {NUM_ITEMS{STOCK_FULL}};
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
            stock_q  <= {NUM_ITEMS{STOCK_FULL}};
            give_q   <= '0;
            change_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            stock_q  <= stock_d;
            give_q   <= give_d;
            change_q <= change_d;
            reject_q <= reject_d;
        end
    end

    assign bus.give          = give_q;
    assign bus.change_nickel = change_q;
    assign bus.coin_reject   = reject_q;
    assign bus.credit        = credit_q;
    assign bus.sold_out      = sold_out;
    assign bus.busy          = (state_q == VEND) || (state_q == CHANGE);

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// -----------------------------------------------------------------------------
// tb_vend_ctrl_multi
// Directed walk-through of the vending scenarios followed by a random phase,
// with every cycle's outputs compared against an integer-level model of the
// vending rules.
// -----------------------------------------------------------------------------
module tb_vend_ctrl_multi;

    localparam int NI    = 2;
    localparam int CW    = 5;
    localparam int MAXC  = 20;
    localparam int PRICE = 9;
    localparam int SW    = 4;
    localparam int SMAX  = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vend_if #(.NUM_ITEMS(NI), .CREDIT_W(CW)) bus ();

    vend_ctrl_multi #(
        .NUM_ITEMS(NI), .CREDIT_W(CW), .MAX_CREDIT(MAXC),
        .PRICE(PRICE), .STOCK_W(SW), .STOCK_MAX(SMAX)
    ) dut (
        .CLK   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Model: credit and stock as plain integers, plus two flags saying whether
    // an item was just handed out and whether nickels are being paid back.
    int m_credit;
    int m_stock [NI];
    bit m_vended;
    bit m_paying;
    int m_give, m_chg, m_rej;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_credit = 0;
        for (int i = 0; i < NI; i++) m_stock[i] = SMAX;
        m_vended = 0;
        m_paying = 0;
        m_give = 0; m_chg = 0; m_rej = 0;
    endtask

    task automatic model_step(input logic n, input logic d, input logic q,
                              input logic [1:0] s, input logic c, input logic r);
        int coins, val, idx;
        coins = int'(n) + int'(d) + int'(q);
        val   = n ? 1 : (d ? 2 : 5);
        m_give = 0; m_chg = 0; m_rej = 0;
        if (m_vended) begin
            m_vended = 0;
            m_rej = (coins > 0) ? 1 : 0;
            if (m_credit > 0) begin
                m_paying = 1; m_credit--; m_chg = 1;
            end
        end else if (m_paying) begin
            m_rej = (coins > 0) ? 1 : 0;
            if (m_credit > 0) begin
                m_credit--; m_chg = 1;
            end else begin
                m_paying = 0;
            end
        end else begin
            idx = (s == 2'b01) ? 0 : ((s == 2'b10) ? 1 : -1);
            if (c && m_credit > 0) begin
                m_paying = 1; m_credit--; m_chg = 1;
                m_rej = (coins > 0) ? 1 : 0;
            end else if (idx >= 0 && m_credit >= PRICE && m_stock[idx] > 0) begin
                m_give = int'(s);
                m_credit -= PRICE;
                m_stock[idx]--;
                m_vended = 1;
                m_rej = (coins > 0) ? 1 : 0;
            end else if (coins == 1 && m_credit + val <= MAXC) begin
                m_credit += val;
            end else if (coins > 0) begin
                m_rej = 1;
            end
        end
        if (r) for (int i = 0; i < NI; i++) m_stock[i] = SMAX;
    endtask

    task automatic compare_all(input string tag);
        int so;
        so = 0;
        for (int i = 0; i < NI; i++) if (m_stock[i] == 0) so |= (1 << i);
        check({tag, ".give"},   int'(bus.give),          m_give);
        check({tag, ".change"}, int'(bus.change_nickel), m_chg);
        check({tag, ".reject"}, int'(bus.coin_reject),   m_rej);
        check({tag, ".credit"}, int'(bus.credit),        m_credit);
        check({tag, ".soldout"},int'(bus.sold_out),      so);
        check({tag, ".busy"},   int'(bus.busy),          int'(m_vended || m_paying));
    endtask

    // One clock: drive inputs, step the model on the edge, compare 1 ns later.
    task automatic tick(input string tag, input logic n, input logic d, input logic q,
                        input logic [1:0] s, input logic c, input logic r);
        bus.N = n; bus.D = d; bus.Q = q;
        bus.sel = s; bus.cancel = c; bus.restock = r;
        @(posedge clk);
        model_step(n, d, q, s, c, r);
        #1;
        compare_all(tag);
        bus.N = 0; bus.D = 0; bus.Q = 0;
        bus.sel = '0; bus.cancel = 0; bus.restock = 0;
    endtask

    task automatic idle(input string tag, input int cnt);
        for (int i = 0; i < cnt; i++) tick(tag, 0, 0, 0, 2'b00, 0, 0);
    endtask

    task automatic vend_ch0(input string tag);
        tick(tag, 0, 0, 1, 2'b00, 0, 0);
        tick(tag, 0, 1, 0, 2'b00, 0, 0);
        tick(tag, 0, 1, 0, 2'b00, 0, 0);
        tick(tag, 0, 0, 0, 2'b01, 0, 0);
        check({tag, ".gave"}, int'(bus.give), 1);
        idle(tag, 1);
    endtask

    initial begin
        logic n, d, q, c, r;
        logic [1:0] s;
        int roll;

        bus.N = 0; bus.D = 0; bus.Q = 0;
        bus.sel = '0; bus.cancel = 0; bus.restock = 0;
        model_reset();

        // Reset state
        #12;
        check("rst.give",    int'(bus.give), 0);
        check("rst.change",  int'(bus.change_nickel), 0);
        check("rst.reject",  int'(bus.coin_reject), 0);
        check("rst.credit",  int'(bus.credit), 0);
        check("rst.soldout", int'(bus.sold_out), 0);
        check("rst.busy",    int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Exact price on channel 0
        tick("tp1", 0, 0, 1, 2'b00, 0, 0);
        tick("tp1", 0, 1, 0, 2'b00, 0, 0);
        tick("tp1", 0, 1, 0, 2'b00, 0, 0);
        check("tp1.credit9", int'(bus.credit), 9);
        tick("tp1", 0, 0, 0, 2'b01, 0, 0);
        check("tp1.give", int'(bus.give), 1);
        check("tp1.credit0", int'(bus.credit), 0);
        tick("tp1", 0, 0, 0, 2'b00, 0, 0);
        check("tp1.give_off", int'(bus.give), 0);
        check("tp1.nochange", int'(bus.change_nickel), 0);
        check("tp1.idle", int'(bus.busy), 0);

        // One nickel of change on channel 1
        tick("tp2", 0, 0, 1, 2'b00, 0, 0);
        tick("tp2", 0, 0, 1, 2'b00, 0, 0);
        tick("tp2", 0, 0, 0, 2'b10, 0, 0);
        check("tp2.give", int'(bus.give), 2);
        check("tp2.busy1", int'(bus.busy), 1);
        tick("tp2", 0, 0, 0, 2'b00, 0, 0);
        check("tp2.change", int'(bus.change_nickel), 1);
        check("tp2.busy2", int'(bus.busy), 1);
        check("tp2.credit0", int'(bus.credit), 0);
        tick("tp2", 0, 0, 0, 2'b00, 0, 0);
        check("tp2.change_off", int'(bus.change_nickel), 0);
        check("tp2.busy_off", int'(bus.busy), 0);

        // Credit ceiling and simultaneous coins
        for (int i = 0; i < 4; i++) tick("tp3", 0, 0, 1, 2'b00, 0, 0);
        check("tp3.credit20", int'(bus.credit), 20);
        tick("tp3", 1, 0, 0, 2'b00, 0, 0);
        check("tp3.over_reject", int'(bus.coin_reject), 1);
        check("tp3.over_credit", int'(bus.credit), 20);
        tick("tp3", 1, 1, 0, 2'b00, 0, 0);
        check("tp3.multi_reject", int'(bus.coin_reject), 1);
        check("tp3.multi_credit", int'(bus.credit), 20);
        tick("tp3", 0, 0, 0, 2'b00, 1, 0);
        idle("tp3", 21);

        // Insufficient credit, then cancel refund
        tick("tp4", 0, 1, 0, 2'b00, 0, 0);
        tick("tp4", 1, 0, 0, 2'b00, 0, 0);
        tick("tp4", 0, 0, 0, 2'b01, 0, 0);
        check("tp4.nogive", int'(bus.give), 0);
        check("tp4.credit3", int'(bus.credit), 3);
        for (int i = 0; i < 3; i++) begin
            tick("tp4", 0, 0, 0, 2'b00, (i == 0), 0);
            check("tp4.refund_pulse", int'(bus.change_nickel), 1);
        end
        check("tp4.credit0", int'(bus.credit), 0);
        tick("tp4", 0, 0, 0, 2'b00, 0, 0);
        check("tp4.idle", int'(bus.busy), 0);
        check("tp4.change_off", int'(bus.change_nickel), 0);

        // Sell out channel 0, blocked selection, restock
        tick("tp5", 0, 0, 0, 2'b00, 0, 1);
        for (int i = 0; i < 10; i++) vend_ch0("tp5");
        check("tp5.soldout", int'(bus.sold_out), 1);
        tick("tp5", 0, 0, 1, 2'b00, 0, 0);
        tick("tp5", 0, 1, 0, 2'b00, 0, 0);
        tick("tp5", 0, 1, 0, 2'b00, 0, 0);
        tick("tp5", 0, 0, 0, 2'b01, 0, 0);
        check("tp5.blocked_give", int'(bus.give), 0);
        check("tp5.blocked_credit", int'(bus.credit), 9);
        tick("tp5", 0, 0, 0, 2'b00, 0, 1);
        check("tp5.restocked", int'(bus.sold_out), 0);
        tick("tp5", 0, 0, 0, 2'b01, 0, 0);
        check("tp5.regive", int'(bus.give), 1);
        idle("tp5", 2);

        // Coin during CHANGE
        tick("tp6", 0, 0, 1, 2'b00, 0, 0);
        tick("tp6", 0, 0, 0, 2'b00, 1, 0);
        tick("tp6", 0, 1, 0, 2'b00, 0, 0);
        check("tp6.chg_reject", int'(bus.coin_reject), 1);
        check("tp6.chg_credit", int'(bus.credit), 3);
        idle("tp6", 5);

        // Reset during the 2nd of 4 change pulses
        for (int i = 0; i < 4; i++) tick("tp7", 1, 0, 0, 2'b00, 0, 0);
        tick("tp7", 0, 0, 0, 2'b00, 1, 0);
        tick("tp7", 0, 0, 0, 2'b00, 0, 0);
        check("tp7.pulse2", int'(bus.change_nickel), 1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("tp7.change_async", int'(bus.change_nickel), 0);
        check("tp7.credit_async", int'(bus.credit), 0);
        check("tp7.busy_async",   int'(bus.busy), 0);
        check("tp7.soldout_async",int'(bus.sold_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle("tp7", 2);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            n = 0; d = 0; q = 0; c = 0; r = 0; s = 2'b00;
            roll = int'($urandom_range(0, 99));
            if (roll < 45) begin
                case ($urandom_range(0, 2))
                    0: n = 1;
                    1: d = 1;
                    default: q = 1;
                endcase
            end else if (roll < 50) begin
                n = 1; d = $urandom_range(0, 1) != 0; q = !d;
            end else if (roll < 56) begin
                c = 1;
            end
            if ($urandom_range(0, 7) == 0) s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 149) == 0) r = 1;
            tick("rand", n, d, q, s, c, r);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
